// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with zero/all-ones/parity flags and a
// running AND/OR mask accumulator, valid/ready on both sides.

package logic_unit_pipe_pkg;

  typedef enum logic [3:0] {
    OP_AND     = 4'd0,
    OP_OR      = 4'd1,
    OP_XOR     = 4'd2,
    OP_NOR     = 4'd3,
    OP_ANDN    = 4'd4,
    OP_NAND    = 4'd5,
    OP_XNOR    = 4'd6,
    OP_PASSA   = 4'd7,
    OP_ACC_AND = 4'd8,
    OP_ACC_OR  = 4'd9,
    OP_ACC_CLR = 4'd10
  } op_e;

endpackage

module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit ACC_INIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_ones,
  output logic             flag_par,
  output logic [WIDTH-1:0] acc_value
);

  localparam logic [WIDTH-1:0] CLEAR_VALUE = ACC_INIT ? '1 : '0;

  logic             adv;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] next_result;
  logic [WIDTH-1:0] next_acc;

  // The whole pipe moves as one; an empty S1 still waits behind a stalled S2.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- stage 1
  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values; blocking writes here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: operand registers carry no reset; s1_valid alone says whether they
  // hold anything meaningful, so resetting them would only cost routing.
  always_ff @(posedge clock) begin
    if (adv && in_valid) begin
      s1_a  <= ina;
      s1_b  <= inb;
      s1_op <= op;
    end
  end

  // ---------------------------------------------------------------- stage 2
  // NOTE: every output of this block gets a default first so that no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    next_result = '0;
    next_acc    = acc_value;
    case (s1_op)
      OP_AND:     next_result = s1_a & s1_b;
      OP_OR:      next_result = s1_a | s1_b;
      OP_XOR:     next_result = s1_a ^ s1_b;
      OP_NOR:     next_result = ~(s1_a | s1_b);
      OP_ANDN:    next_result = s1_a & ~s1_b;
      OP_NAND:    next_result = ~(s1_a & s1_b);
      OP_XNOR:    next_result = ~(s1_a ^ s1_b);
      OP_PASSA:   next_result = s1_a;
      OP_ACC_AND: begin
        next_result = acc_value & s1_a;
        next_acc    = next_result;
      end
      OP_ACC_OR: begin
        next_result = acc_value | s1_a;
        next_acc    = next_result;
      end
      OP_ACC_CLR: begin
        next_result = CLEAR_VALUE;
        next_acc    = CLEAR_VALUE;
      end
      default:    next_result = '0;
    endcase
  end

  // Accumulator shares the result's edge, so a following ACC op in S1 always
  // reads the value its predecessor just wrote.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_zero <= 1'b1;
      flag_ones <= 1'b0;
      flag_par  <= 1'b0;
      acc_value <= CLEAR_VALUE;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result    <= next_result;
        flag_zero <= (next_result == '0);
        flag_ones <= &next_result;
        flag_par  <= ^next_result;
        acc_value <= next_acc;
      end
    end
  end

  // A result offered but not taken must stay put until the consumer takes it.
  a_hold_on_stall : assert property (
    @(posedge clock) disable iff (!reset_n)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(result) && $stable(acc_value) &&
       $stable(flag_zero) && $stable(flag_ones) && $stable(flag_par))
  );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed, table-driven bench for logic_unit_pipe: two 32-bit instances
// (clear value zeros / ones) and one 8-bit instance share control inputs.

module tb_logic_unit_pipe;
  import logic_unit_pipe_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ones;
    logic        par;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] res_a;
    logic [31:0] acc_a;
    logic [31:0] res_b;
    logic [31:0] acc_b;
  } acc_vec_t;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic [31:0] ina;
  logic [31:0] inb;
  logic [7:0]  ina8;
  logic [7:0]  inb8;

  logic        a_in_ready, a_out_valid, a_zero, a_ones, a_par;
  logic [31:0] a_result, a_acc;
  logic        b_in_ready, b_out_valid, b_zero, b_ones, b_par;
  logic [31:0] b_result, b_acc;
  logic        c_in_ready, c_out_valid, c_zero, c_ones, c_par;
  logic [7:0]  c_result, c_acc;

  int checks = 0;
  int errors = 0;

  logic_unit_pipe #(.WIDTH(32), .ACC_INIT(1'b0)) dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .ina(ina), .inb(inb), .op(op), .out_valid(a_out_valid), .out_ready(out_ready),
    .result(a_result), .flag_zero(a_zero), .flag_ones(a_ones), .flag_par(a_par),
    .acc_value(a_acc)
  );

  logic_unit_pipe #(.WIDTH(32), .ACC_INIT(1'b1)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .ina(ina), .inb(inb), .op(op), .out_valid(b_out_valid), .out_ready(out_ready),
    .result(b_result), .flag_zero(b_zero), .flag_ones(b_ones), .flag_par(b_par),
    .acc_value(b_acc)
  );

  logic_unit_pipe #(.WIDTH(8), .ACC_INIT(1'b0)) dut_c (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .ina(ina8), .inb(inb8), .op(op), .out_valid(c_out_valid), .out_ready(out_ready),
    .result(c_result), .flag_zero(c_zero), .flag_ones(c_ones), .flag_par(c_par),
    .acc_value(c_acc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  vec_t     vecs[10];
  acc_vec_t avecs[6];
  logic [7:0] w8_a[3];
  logic [7:0] w8_b[3];
  logic [3:0] w8_op[3];
  logic [7:0] w8_res[3];
  logic [2:0] w8_flags[3];

  initial begin
    vecs[0] = '{OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{OP_XOR,   32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{OP_OR,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{OP_NOR,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{OP_ANDN,  32'hFFFF_00FF, 32'h0F0F_0F0F, 32'hF0F0_00F0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_NAND,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{OP_XNOR,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{OP_PASSA, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0007, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{4'd13,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{OP_XOR,   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1};

    // Instance a clears to zeros, instance b to ones.
    avecs[0] = '{OP_ACC_AND, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    avecs[1] = '{OP_ACC_CLR, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    avecs[2] = '{OP_ACC_AND, 32'hFFFF_00FF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_00FF, 32'hFFFF_00FF};
    avecs[3] = '{OP_ACC_AND, 32'h0FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0FFF_00FF, 32'h0FFF_00FF};
    avecs[4] = '{OP_ACC_OR,  32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_00FF, 32'hFFFF_00FF};
    avecs[5] = '{4'd13,      32'hFFFF_FFFF, 32'h0000_0000, 32'hF000_0000, 32'h0000_0000, 32'hFFFF_00FF};

    // 8-bit rerun of the streaming pattern; flags packed as {zero, ones, par}.
    w8_op[0] = OP_AND; w8_a[0] = 8'hF0; w8_b[0] = 8'hCC; w8_res[0] = 8'hC0; w8_flags[0] = 3'b000;
    w8_op[1] = OP_XOR; w8_a[1] = 8'hF0; w8_b[1] = 8'h0F; w8_res[1] = 8'hFF; w8_flags[1] = 3'b010;
    w8_op[2] = OP_NOR; w8_a[2] = 8'h0F; w8_b[2] = 8'hF0; w8_res[2] = 8'h00; w8_flags[2] = 3'b100;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    ina       = '0;
    inb       = '0;
    ina8      = '0;
    inb8      = '0;

    // ---------------------------------------------------------- reset state
    step();
    step();
    check("rst out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst result",    a_result, 32'd0);
    check("rst flag_zero", {31'd0, a_zero}, 32'd1);
    check("rst flag_ones", {31'd0, a_ones}, 32'd0);
    check("rst flag_par",  {31'd0, a_par}, 32'd0);
    check("rst in_ready",  {31'd0, a_in_ready}, 32'd1);
    check("rst acc a",     a_acc, 32'h0000_0000);
    check("rst acc b",     b_acc, 32'hFFFF_FFFF);
    reset_n = 1'b1;
    step();

    // ------------------------------------------------- streaming op table
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) begin
        in_valid = 1'b1;
        op       = vecs[k].op;
        ina      = vecs[k].a;
        inb      = vecs[k].b;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k >= 1) begin
        check($sformatf("vec%0d out_valid", k - 1), {31'd0, a_out_valid}, 32'd1);
        check($sformatf("vec%0d result", k - 1), a_result, vecs[k-1].res);
        check($sformatf("vec%0d flags", k - 1), {29'd0, a_zero, a_ones, a_par},
              {29'd0, vecs[k-1].zero, vecs[k-1].ones, vecs[k-1].par});
      end
    end
    step();
    check("bubble out_valid", {31'd0, a_out_valid}, 32'd0);
    check("bubble result",    a_result, 32'h8000_0000);
    check("logic ops acc a",  a_acc, 32'h0000_0000);
    check("logic ops acc b",  b_acc, 32'hFFFF_FFFF);

    // --------------------------------------------------------- backpressure
    in_valid = 1'b1; op = OP_AND; ina = 32'h0000_FFFF; inb = 32'h00FF_00FF;
    step();
    op = OP_OR; ina = 32'h0F00_0000; inb = 32'h0000_00F0;
    step();
    check("bp first valid",  {31'd0, a_out_valid}, 32'd1);
    check("bp first result", a_result, 32'h0000_00FF);
    out_ready = 1'b0;
    op = OP_XOR; ina = 32'hAAAA_AAAA; inb = 32'hFFFF_FFFF;
    #1;
    check("bp in_ready low", {31'd0, a_in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("bp hold%0d result", i), a_result, 32'h0000_00FF);
      check($sformatf("bp hold%0d valid", i), {31'd0, a_out_valid}, 32'd1);
      check($sformatf("bp hold%0d in_ready", i), {31'd0, a_in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", {31'd0, a_in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp second result", a_result, 32'h0F00_00F0);
    check("bp second valid",  {31'd0, a_out_valid}, 32'd1);
    step();
    check("bp third result", a_result, 32'h5555_5555);
    check("bp third valid",  {31'd0, a_out_valid}, 32'd1);
    step();
    check("bp drained valid",  {31'd0, a_out_valid}, 32'd0);
    check("bp drained result", a_result, 32'h5555_5555);

    // ---------------------------------------------------------- accumulator
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        in_valid = 1'b1;
        op       = avecs[k].op;
        ina      = avecs[k].a;
        inb      = 32'h0;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k >= 1) begin
        check($sformatf("acc%0d result a", k - 1), a_result, avecs[k-1].res_a);
        check($sformatf("acc%0d acc a", k - 1),    a_acc,    avecs[k-1].acc_a);
        check($sformatf("acc%0d result b", k - 1), b_result, avecs[k-1].res_b);
        check($sformatf("acc%0d acc b", k - 1),    b_acc,    avecs[k-1].acc_b);
      end
    end
    check("reserved zero flag b", {31'd0, b_zero}, 32'd1);

    // ------------------------------------------------------ reset mid-flight
    in_valid = 1'b1; op = OP_ACC_OR; ina = 32'h0000_00FF;
    step();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    step();
    check("midrst out_valid a", {31'd0, a_out_valid}, 32'd0);
    check("midrst out_valid b", {31'd0, b_out_valid}, 32'd0);
    check("midrst acc a",       a_acc, 32'h0000_0000);
    check("midrst acc b",       b_acc, 32'hFFFF_FFFF);
    check("midrst result a",    a_result, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("midrst quiet%0d a", i), {31'd0, a_out_valid}, 32'd0);
      check($sformatf("midrst quiet%0d b", i), {31'd0, b_out_valid}, 32'd0);
    end
    check("midrst acc a after", a_acc, 32'h0000_0000);

    // ------------------------------------------------------- WIDTH=8 rerun
    for (int k = 0; k <= 3; k++) begin
      if (k < 3) begin
        in_valid = 1'b1;
        op       = w8_op[k];
        ina8     = w8_a[k];
        inb8     = w8_b[k];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k >= 1) begin
        check($sformatf("w8 vec%0d valid", k - 1), {31'd0, c_out_valid}, 32'd1);
        check($sformatf("w8 vec%0d result", k - 1), {24'd0, c_result}, {24'd0, w8_res[k-1]});
        check($sformatf("w8 vec%0d flags", k - 1), {29'd0, c_zero, c_ones, c_par},
              {29'd0, w8_flags[k-1]});
      end
    end
    step();
    check("w8 drained valid", {31'd0, c_out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
